// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_scan_pkg : shared types and constants for the 4:1 mux scan controller
// Revision     : 1.0
// ----------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_scan_ctrl_if : control, mux-side and downstream handshake signals
// Revision         : 1.0
// ----------------------------------------------------------------------------
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              start;
    logic              continuous;
    logic              abort;
    logic              y;
    logic              sel1;
    logic              sel0;
    logic [NUM_CH-1:0] word;
    logic              word_valid;
    logic              word_ready;
    logic              busy;

    modport master (
        input  start, continuous, abort, y, word_ready,
        output sel1, sel0, word, word_valid, busy
    );

    modport slave (
        output start, continuous, abort, y, word_ready,
        input  sel1, sel0, word, word_valid, busy
    );

endinterface
`default_nettype wire

// File: rtl/mux_scan_settle_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_scan_settle_cnt : loadable down-counter, done while the count is zero
// Revision            : 1.0
// ----------------------------------------------------------------------------
module mux_scan_settle_cnt #(
    parameter int               WIDTH    = 2,
    parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_scan_ctrl : steps a 4:1 mux through all channels, packs samples of y
//                 into a word and offers it downstream on valid/ready
// Revision      : 1.0
// ----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.master bus
);

    state_e            state_q;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   ch_d;
    logic [CH_W-1:0]   sel_q;
    logic [NUM_CH-2:0] buf_q;
    logic [NUM_CH-1:0] word_q;
    logic              valid_q;
    logic              busy_q;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_done;

    assign ch_d = ch_q + 1'b1;

    // Counter stays preloaded outside SETTLE so the first channel gets a full dwell.
    assign cnt_en   = (state_q == SETTLE);
    assign cnt_load = (state_q != SETTLE) || cnt_done;

    mux_scan_settle_cnt #(
        .WIDTH    (CNT_W),
        .LOAD_VAL (CNT_W'(SETTLE_CYCLES - 1))
    ) u_settle_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .done_o (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            sel_q   <= '0;
            buf_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (bus.abort) begin
            state_q <= IDLE;
            ch_q    <= '0;
            sel_q   <= '0;
            buf_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= SETTLE;
                        ch_q    <= '0;
                        sel_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_done) begin
                        if (ch_q == LAST_CH) begin
                            // Channel 3 goes straight into the word; lower channels shift in from the top.
                            word_q  <= {bus.y, buf_q};
                            valid_q <= 1'b1;
                            sel_q   <= {CH_W{1'b1}};
                            state_q <= PRESENT;
                        end else begin
                            buf_q <= {bus.y, buf_q[NUM_CH-2:1]};
                            ch_q  <= ch_d;
                            sel_q <= ch_d;
                        end
                    end
                end
                PRESENT: begin
                    if (valid_q && bus.word_ready) begin
                        valid_q <= 1'b0;
                        ch_q    <= '0;
                        sel_q   <= '0;
                        if (bus.continuous) begin
                            state_q <= SETTLE;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel1       = sel_q[1];
    assign bus.sel0       = sel_q[0];
    assign bus.word       = word_q;
    assign bus.word_valid = valid_q;
    assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mux_scan_ctrl : two controllers (settle 2 and settle 1) each driving a 4:1 mux
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    localparam int S0 = 2;
    localparam int S1 = 1;

    logic       clk;
    logic [1:0] rst_r;
    logic [1:0] start_r;
    logic [1:0] cont_r;
    logic [1:0] abort_r;
    logic [1:0] ready_r;
    logic [3:0] d_r [2];

    logic [1:0] sel_o [2];
    logic [3:0] word_o [2];
    logic [1:0] valid_o;
    logic [1:0] busy_o;

    int         n_checks = 0;
    int         n_errors = 0;

    // Expected behaviour: scan phase counts cycles since the scan began (-1 idle, 4*S presenting)
    int         m_ph [2]   = '{-1, -1};
    logic [3:0] m_cap [2]  = '{4'b0, 4'b0};
    logic [3:0] m_word [2] = '{4'b0, 4'b0};

    mux_scan_ctrl_if if0 ();
    mux_scan_ctrl_if if1 ();

    assign if0.start      = start_r[0];
    assign if0.continuous = cont_r[0];
    assign if0.abort      = abort_r[0];
    assign if0.word_ready = ready_r[0];
    assign if0.y          = d_r[0][{if0.sel1, if0.sel0}];
    assign if1.start      = start_r[1];
    assign if1.continuous = cont_r[1];
    assign if1.abort      = abort_r[1];
    assign if1.word_ready = ready_r[1];
    assign if1.y          = d_r[1][{if1.sel1, if1.sel0}];

    assign sel_o[0]   = {if0.sel1, if0.sel0};
    assign sel_o[1]   = {if1.sel1, if1.sel0};
    assign word_o[0]  = if0.word;
    assign word_o[1]  = if1.word;
    assign valid_o[0] = if0.word_valid;
    assign valid_o[1] = if1.word_valid;
    assign busy_o[0]  = if0.busy;
    assign busy_o[1]  = if1.busy;

    mux_scan_ctrl #(.SETTLE_CYCLES(S0)) dut0 (
        .clk (clk),
        .rst (rst_r[0]),
        .bus (if0)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(S1)) dut1 (
        .clk (clk),
        .rst (rst_r[1]),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_upd(input int k);
        int s;
        s = (k == 0) ? S0 : S1;
        if (rst_r[k]) begin
            m_ph[k]   <= -1;
            m_word[k] <= 4'b0;
        end else if (abort_r[k]) begin
            m_ph[k] <= -1;
        end else if (m_ph[k] < 0) begin
            if (start_r[k]) m_ph[k] <= 0;
        end else if (m_ph[k] < 4 * s) begin
            if (((m_ph[k] + 1) % s) == 0) begin
                int i;
                i = (m_ph[k] + 1) / s - 1;
                m_cap[k][i] <= d_r[k][i];
                if (i == 3) m_word[k] <= {d_r[k][3], m_cap[k][2:0]};
            end
            m_ph[k] <= m_ph[k] + 1;
        end else if (ready_r[k]) begin
            m_ph[k] <= cont_r[k] ? 0 : -1;
        end
    endtask

    always @(posedge clk) begin
        model_upd(0);
        model_upd(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int s;
            int ph;
            int es;
            s  = (k == 0) ? S0 : S1;
            ph = m_ph[k];
            if (ph < 0)          es = 0;
            else if (ph < 4 * s) es = ph / s;
            else                 es = 3;
            chk($sformatf("sel[%0d]", k),   32'(sel_o[k]),   32'(es));
            chk($sformatf("busy[%0d]", k),  32'(busy_o[k]),  32'(ph >= 0));
            chk($sformatf("valid[%0d]", k), 32'(valid_o[k]), 32'(ph == 4 * s));
            chk($sformatf("word[%0d]", k),  32'(word_o[k]),  32'(m_word[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic start_pulse(input int k);
        start_r[k] = 1'b1;
        step();
        start_r[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_r   = 2'b11;
        start_r = 2'b00;
        cont_r  = 2'b00;
        abort_r = 2'b00;
        ready_r = 2'b00;
        d_r[0]  = 4'b0000;
        d_r[1]  = 4'b0000;
        step();
        step();
        chk("rst_sel",   32'(sel_o[0]),   32'd0);
        chk("rst_word",  32'(word_o[0]),  32'd0);
        chk("rst_valid", 32'(valid_o[0]), 32'd0);
        chk("rst_busy",  32'(busy_o[0]),  32'd0);
        rst_r = 2'b00;
        step();

        // 1: single scan, ready high, 2-cycle dwell per channel
        d_r[0]     = 4'b1010;
        ready_r[0] = 1'b1;
        start_pulse(0);
        chk("t1_sel_e0", 32'(sel_o[0]), 32'd0);
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e < 8) begin
                chk("t1_sel_seq",   32'(sel_o[0]),   32'(e / 2));
                chk("t1_valid_low", 32'(valid_o[0]), 32'd0);
            end
        end
        chk("t1_valid", 32'(valid_o[0]), 32'd1);
        chk("t1_word",  32'(word_o[0]),  32'b1010);
        chk("t1_sel11", 32'(sel_o[0]),   32'd3);
        step();
        chk("t1_idle_busy", 32'(busy_o[0]),  32'd0);
        chk("t1_idle_sel",  32'(sel_o[0]),   32'd0);
        chk("t1_hs_valid",  32'(valid_o[0]), 32'd0);
        chk("t1_word_kept", 32'(word_o[0]),  32'b1010);

        // 2: backpressure for 5 cycles, plus a start while busy
        d_r[0]     = 4'b0101;
        ready_r[0] = 1'b0;
        start_pulse(0);
        for (int e = 1; e <= 8; e++) begin
            start_r[0] = (e == 3);
            step();
        end
        start_r[0] = 1'b0;
        for (int h = 0; h < 5; h++) begin
            step();
            chk("t2_hold_valid", 32'(valid_o[0]), 32'd1);
            chk("t2_hold_word",  32'(word_o[0]),  32'b0101);
            chk("t2_hold_sel",   32'(sel_o[0]),   32'd3);
        end
        ready_r[0] = 1'b1;
        step();
        chk("t2_xfer_valid", 32'(valid_o[0]), 32'd0);
        chk("t2_xfer_busy",  32'(busy_o[0]),  32'd0);
        step();
        chk("t2_single_xfer", 32'(valid_o[0]), 32'd0);

        // 3: continuous mode, dropped during the second scan
        d_r[0]    = 4'b0110;
        cont_r[0] = 1'b1;
        start_pulse(0);
        for (int e = 1; e <= 8; e++) step();
        chk("t3_word_a", 32'(word_o[0]),  32'b0110);
        chk("t3_valid_a", 32'(valid_o[0]), 32'd1);
        step();
        chk("t3_rescan_busy", 32'(busy_o[0]), 32'd1);
        cont_r[0] = 1'b0;
        d_r[0]    = 4'b1001;
        for (int e = 1; e <= 8; e++) step();
        chk("t3_word_b",  32'(word_o[0]),  32'b1001);
        chk("t3_valid_b", 32'(valid_o[0]), 32'd1);
        step();
        chk("t3_idle", 32'(busy_o[0]), 32'd0);

        // 4: reset while channel 2 is selected
        d_r[0] = 4'b1010;
        start_pulse(0);
        for (int e = 1; e <= 4; e++) step();
        chk("t4_ch2", 32'(sel_o[0]), 32'd2);
        rst_r[0] = 1'b1;
        step();
        rst_r[0] = 1'b0;
        chk("t4_rst_sel",   32'(sel_o[0]),   32'd0);
        chk("t4_rst_busy",  32'(busy_o[0]),  32'd0);
        chk("t4_rst_valid", 32'(valid_o[0]), 32'd0);
        chk("t4_rst_word",  32'(word_o[0]),  32'd0);
        d_r[0] = 4'b1100;
        start_pulse(0);
        for (int e = 1; e <= 8; e++) step();
        chk("t4_fresh_word", 32'(word_o[0]), 32'b1100);
        step();

        // 5: abort with ready during PRESENT, then abort mid-settle
        d_r[0]     = 4'b0011;
        ready_r[0] = 1'b0;
        start_pulse(0);
        for (int e = 1; e <= 8; e++) step();
        chk("t5_present", 32'(valid_o[0]), 32'd1);
        abort_r[0] = 1'b1;
        ready_r[0] = 1'b1;
        step();
        abort_r[0] = 1'b0;
        chk("t5_abort_valid", 32'(valid_o[0]), 32'd0);
        chk("t5_abort_busy",  32'(busy_o[0]),  32'd0);
        chk("t5_abort_sel",   32'(sel_o[0]),   32'd0);
        chk("t5_abort_word",  32'(word_o[0]),  32'b0011);
        step();
        chk("t5_no_xfer", 32'(valid_o[0]), 32'd0);
        start_pulse(0);
        for (int e = 1; e <= 3; e++) step();
        abort_r[0] = 1'b1;
        step();
        abort_r[0] = 1'b0;
        chk("t5_mid_abort_busy", 32'(busy_o[0]), 32'd0);
        d_r[0] = 4'b0101;
        start_pulse(0);
        for (int e = 1; e <= 8; e++) step();
        chk("t5_after_abort_word", 32'(word_o[0]), 32'b0101);
        step();

        // 6: one-cycle dwell on the second controller
        d_r[1]     = 4'b1111;
        ready_r[1] = 1'b1;
        start_pulse(1);
        for (int e = 1; e <= 4; e++) begin
            step();
            if (e < 4) chk("t6_valid_low", 32'(valid_o[1]), 32'd0);
        end
        chk("t6_valid", 32'(valid_o[1]), 32'd1);
        chk("t6_word",  32'(word_o[1]),  32'b1111);
        step();
        chk("t6_idle", 32'(busy_o[1]), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
